// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data memory port arbiter between the CPU MEM stage and a DMA requester
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_lock,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

    localparam logic [3:0] WAIT_MAX  = 4'(MAX_WAIT);
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    owner_t     owner, owner_nxt;
    logic [3:0] wait_cnt, wait_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    logic       dma_win, cpu_win, cpu_gnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= OWN_CPU;
            wait_cnt   <= 4'd0;
            burst_cnt  <= 4'd0;
            dma_rdata  <= '0;
            dma_rvalid <= 1'b0;
        end else begin
            owner      <= owner_nxt;
            wait_cnt   <= wait_nxt;
            burst_cnt  <= burst_nxt;
            dma_rvalid <= dma_win && !dma_we;
            if (dma_win && !dma_we)
                dma_rdata <= mem_rdata;
        end
    end

    always_comb begin
        dma_win   = 1'b0;
        owner_nxt = owner;
        wait_nxt  = wait_cnt;
        burst_nxt = burst_cnt;
        case (owner)
            OWN_CPU: dma_win = dma_req && (!cpu_req || wait_cnt == WAIT_MAX);
            OWN_DMA: dma_win = dma_req && !(cpu_req && burst_cnt == BURST_MAX);
            default: dma_win = 1'b0;
        endcase
        cpu_win = cpu_req && !dma_win;

        if (!dma_req || dma_win)
            wait_nxt = 4'd0;
        else if (cpu_win && wait_cnt != WAIT_MAX)
            wait_nxt = wait_cnt + 4'd1;

        // burst_cnt counts beats already granted in the current burst, the entry beat included,
        // so a locked burst contending with the CPU yields exactly MAX_BURST grants
        case (owner)
            OWN_CPU: begin
                if (dma_win && dma_lock) begin
                    owner_nxt = OWN_DMA;
                    burst_nxt = 4'd1;
                end
            end
            OWN_DMA: begin
                if (dma_win && dma_lock) begin
                    if (burst_cnt != BURST_MAX)
                        burst_nxt = burst_cnt + 4'd1;
                end else begin
                    owner_nxt = OWN_CPU;
                    burst_nxt = 4'd0;
                end
            end
            default: owner_nxt = OWN_CPU;
        endcase
    end

    always_comb begin
        dma_gnt   = !reset && dma_win;
        cpu_gnt   = !reset && cpu_win;
        cpu_stall = !reset && cpu_req && !cpu_win;
        cpu_rdata = mem_rdata;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
            mem_re    = !dma_we;
        end else if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
            mem_re    = !cpu_we;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and random checks of dmem_arbiter against a bench-owned memory
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we, dma_lock;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;

    logic [31:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[9:2]];

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_lock = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        idle();
        cpu_req = 1; dma_req = 1; dma_we = 1;
        #2;
        checks++;
        if ({mem_we, mem_re, dma_gnt, cpu_stall, dma_rvalid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got we/re/gnt/stall/rvalid=%b required 00000",
                     {mem_we, mem_re, dma_gnt, cpu_stall, dma_rvalid});
        end
        checks++;
        if (dma_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_dma_rdata got %h required 00000000", dma_rdata);
        end
        next_cycle();
        idle();
        reset = 0;
        next_cycle();
    endtask

    task automatic test_cpu_read();
        mem[4] = 32'h1234_5678;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        @(negedge clk);
        checks++;
        if ({mem_re, mem_we, cpu_stall, dma_gnt} !== 4'b1000 || mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL cpu_read got re/we/stall/gnt=%b addr=%h required 1000 addr=00000010",
                     {mem_re, mem_we, cpu_stall, dma_gnt}, mem_addr);
        end
        checks++;
        if (cpu_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL cpu_rdata got %h required 12345678", cpu_rdata);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_dma_write_read();
        dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({dma_gnt, mem_we, mem_re} !== 3'b110 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL dma_write got gnt/we/re=%b addr=%h wdata=%h required 110 00000020 deadbeef",
                     {dma_gnt, mem_we, mem_re}, mem_addr, mem_wdata);
        end
        next_cycle();
        checks++;
        if (mem[8] !== 32'hDEAD_BEEF || dma_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL dma_write_commit got mem=%h rvalid=%b required deadbeef 0", mem[8], dma_rvalid);
        end
        dma_we = 0; dma_wdata = 0;
        @(negedge clk);
        checks++;
        if ({dma_gnt, mem_re, mem_we} !== 3'b110) begin
            errors++;
            $display("FAIL dma_read_gnt got gnt/re/we=%b required 110", {dma_gnt, mem_re, mem_we});
        end
        next_cycle();
        idle();
        checks++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL dma_read_data got rvalid=%b data=%h required 1 deadbeef", dma_rvalid, dma_rdata);
        end
        next_cycle();
        checks++;
        if (dma_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL dma_rvalid_pulse got %b required 0", dma_rvalid);
        end
    endtask

    task automatic test_collision();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hAAAA_0001;
        dma_req = 1; dma_we = 1; dma_addr = 32'h30; dma_wdata = 32'hBBBB_0002;
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0 || mem_wdata !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL collision_grant got gnt=%b stall=%b wdata=%h required 0 0 aaaa0001",
                     dma_gnt, cpu_stall, mem_wdata);
        end
        next_cycle();
        idle();
        checks++;
        if (mem[12] !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL collision_mem got %h required aaaa0001", mem[12]);
        end
        next_cycle();
    endtask

    task automatic test_starvation();
        cpu_req = 1; dma_req = 1; dma_lock = 0;
        cpu_addr = 32'h40; dma_addr = 32'h44;
        for (int i = 0; i < 10; i++) begin
            logic exp_dma;
            exp_dma = (i % 5 == 4);
            @(negedge clk);
            checks++;
            if (dma_gnt !== exp_dma || cpu_stall !== exp_dma) begin
                errors++;
                $display("FAIL starvation cycle %0d got gnt=%b stall=%b required %b %b",
                         i, dma_gnt, cpu_stall, exp_dma, exp_dma);
            end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_burst();
        cpu_req = 1; dma_req = 1; dma_lock = 1;
        cpu_addr = 32'h50; dma_addr = 32'h54;
        for (int i = 0; i < 17; i++) begin
            logic exp_dma;
            exp_dma = (i >= 4 && i <= 11) || i == 16;
            @(negedge clk);
            checks++;
            if (dma_gnt !== exp_dma || cpu_stall !== exp_dma) begin
                errors++;
                $display("FAIL burst cycle %0d got gnt=%b stall=%b required %b %b",
                         i, dma_gnt, cpu_stall, exp_dma, exp_dma);
            end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        mem[19] = 32'h0;
        dma_req = 1; dma_we = 1; dma_lock = 1;
        for (int i = 0; i < 3; i++) begin
            dma_addr = 32'h40 + 32'(4 * i);
            dma_wdata = 32'hAAAA_0000 + 32'(i);
            next_cycle();
        end
        dma_addr = 32'h4C; dma_wdata = 32'hAAAA_0003;
        #1 reset = 1;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || dma_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_burst got we=%b gnt=%b required 0 0", mem_we, dma_gnt);
        end
        next_cycle();
        checks++;
        if (mem[19] !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_burst_mem got %h required 00000000", mem[19]);
        end
        reset = 0;
        cpu_req = 1; cpu_addr = 32'h60;
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_owner got gnt=%b stall=%b required 0 0", dma_gnt, cpu_stall);
        end
        next_cycle();
        cpu_req = 0; dma_lock = 0;
        next_cycle();
        idle();
        checks++;
        if (mem[19] !== 32'hAAAA_0003) begin
            errors++;
            $display("FAIL post_reset_write got %h required aaaa0003", mem[19]);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic        exp_rvalid = 0;
        logic [31:0] exp_rdata = 0;
        int          waited = 0;
        for (int c = 0; c < 3000; c++) begin
            logic gnt, cpu_ok;
            if (!dma_req && $urandom_range(0, 2) == 0) begin
                dma_req = 1; dma_we = 1'($urandom_range(0, 1));
                dma_addr = {22'h0, 8'($urandom), 2'b00}; dma_wdata = $urandom;
            end
            dma_lock = 1'($urandom_range(0, 1));
            cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = {22'h0, 8'($urandom), 2'b00}; cpu_wdata = $urandom;
            @(negedge clk);
            gnt = dma_gnt;
            cpu_ok = cpu_req && !cpu_stall;
            checks++;
            if (gnt && cpu_ok) begin
                errors++;
                $display("FAIL invariant cycle %0d got both granted required at most one", c);
            end
            checks++;
            if (dma_rvalid !== exp_rvalid || (exp_rvalid && dma_rdata !== exp_rdata)) begin
                errors++;
                $display("FAIL random_dma_read cycle %0d got %b %h required %b %h",
                         c, dma_rvalid, dma_rdata, exp_rvalid, exp_rdata);
            end
            if (cpu_ok && !cpu_we && cpu_rdata !== mem[cpu_addr[9:2]]) begin
                errors++;
                $display("FAIL random_cpu_read cycle %0d got %h required %h",
                         c, cpu_rdata, mem[cpu_addr[9:2]]);
            end
            exp_rvalid = gnt && !dma_we;
            exp_rdata = mem[dma_addr[9:2]];
            waited = (dma_req && !gnt) ? waited + 1 : 0;
            if (waited > 12) begin
                errors++;
                $display("FAIL dma_wait cycle %0d got %0d required <= 12", c, waited);
            end
            next_cycle();
            if (gnt) dma_req = 0;
        end
        idle();
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i) * 32'h0101_0101;
        test_reset();
        test_cpu_read();
        test_dma_write_read();
        test_collision();
        test_starvation();
        test_burst();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
